dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles before response (legal 0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce_i  input  1  request valid (chip enable), held by initiator until ack_o/err_o.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32  byte address; bits [1:0] ignored, word index = addr_i[31:2].
REQ-008 SHALL have port sel_i  input  4  byte-lane enables, big-endian: sel_i[3] = data bits 31:24, sel_i[0] = bits 7:0.
REQ-009 SHALL have port data_i  input  32  write data, lanes already replicated/aligned by initiator.
REQ-010 SHALL have port data_o  output  32  read data, full word, registered.
REQ-011 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  output  1  one-cycle error-completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: ce_i=1 -> latch we_i/addr_i/sel_i/data_i, load wait counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: counter decrements each cycle; at 0 go RESP; ce_i=0 in WAIT -> abort to IDLE, no write, no ack/err.
REQ-016 RESP: exactly one of ack_o/err_o high for exactly one cycle; next state IDLE.
REQ-017 Latency: ack_o/err_o high WAIT_STATES+1 cycles after the edge sampling ce_i=1 in IDLE.
REQ-018 Request still asserted in the cycle after RESP SHALL be accepted as a new transaction (back-to-back allowed; min 2-cycle throughput at WAIT_STATES=0).
REQ-019 Legal sel_i: 1000,0100,0010,0001,1100,0011,1111; any other value incl. 0000 -> err_o, no write, data_o unchanged.
REQ-020 addr_i[31:2] >= DEPTH_WORDS -> err_o, no write, data_o unchanged.
REQ-021 Legal write: lanes with sel bit 1 updated from corresponding data_i byte at the edge entering RESP; other lanes unchanged.
REQ-022 Legal read: data_o loaded with whole stored word at the edge entering RESP (sel_i does not mask); held until next legal read.
REQ-023 Read of a word written by the immediately preceding transaction SHALL return the new value.
REQ-024 Latched request values SHALL be used; input changes after acceptance have no effect except ce_i abort.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, counter 0, data_o=0, ack_o=0, err_o=0.
REQ-026 rst mid-WAIT SHALL abort the pending transaction with no write and no response.
REQ-027 Storage array SHALL NOT be cleared by reset; contents undefined until written.
REQ-028 ce_i is ignored in any cycle where rst=1.

Structure
REQ-029 ChipEnable/WriteEnable levels, RegBus width and the legal sel encodings SHALL come from the shared defines file.
REQ-030 FSM state encodings SHALL be local to the module.
REQ-031 Storage SHALL be four instances of sub-module dmem_byte_bank (8-bit wide, DEPTH_WORDS deep, one write enable per bank).

Verification
REQ-032 WAIT_STATES=1: write addr 0x10, sel 1111, data 0xDEADBEEF; then read 0x10 -> ack_o 2 cycles after acceptance, data_o=0xDEADBEEF.
REQ-033 Byte write addr 0x13, sel 0001, data 0x55555555 over 0xDEADBEEF, read 0x10 -> 0xDEADBE55; halfword sel 1100 data 0x12341234 -> 0x1234BE55.
REQ-034 Read addr 4*DEPTH_WORDS (0x1000) -> err_o one cycle, ack_o 0, data_o unchanged; write sel 0101 -> err_o, word unchanged.
REQ-035 Write accepted, ce_i dropped during WAIT -> no ack/err, subsequent read shows old contents.
REQ-036 WAIT_STATES=0, ce_i held high for 4 back-to-back writes to 0x0,0x4,0x8,0xC -> ack_o every second cycle, all four words stored.
REQ-037 rst asserted during WAIT of a write -> no response, outputs 0 next cycle, word unchanged on read-back.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared bus definitions for the data-memory responder: enable levels, bus width
// and the byte-lane select encodings the responder accepts.
package dmem_responder_pkg;

  localparam int unsigned REG_BUS_W    = 32;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;

  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      SEL_B3, SEL_B2, SEL_B1, SEL_B0, SEL_HI, SEL_LO, SEL_WORD: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of data memory: synchronous write, combinational read.
module dmem_byte_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accepts one request, waits WAIT_STATES cycles,
// performs the access, then pulses ack_o or err_o.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [3:0]           sel_i,
  input  logic [REG_BUS_W-1:0] data_i,
  output logic [REG_BUS_W-1:0] data_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [3:0]           r_sel;
  logic [REG_BUS_W-1:0] r_data;
  logic                 r_err;

  logic                 w_we;
  logic [31:0]          w_addr;
  logic [3:0]           w_sel;
  logic [REG_BUS_W-1:0] w_data;
  logic                 w_enter_resp;
  logic                 w_legal;
  logic [3:0]           w_bank_we;
  logic [REG_BUS_W-1:0] w_rdata;
  logic                 w_unused_addr;

  // With no wait states the access happens on the accepting edge, so use live inputs there.
  assign w_we   = (r_state == StIdle) ? we_i   : r_we;
  assign w_addr = (r_state == StIdle) ? addr_i : r_addr;
  assign w_sel  = (r_state == StIdle) ? sel_i  : r_sel;
  assign w_data = (r_state == StIdle) ? data_i : r_data;
  assign w_unused_addr = ^w_addr[1:0];

  assign w_enter_resp = !rst && (ce_i == CHIP_ENABLE) &&
                        (((r_state == StIdle) && (WAIT_STATES == 0)) ||
                         ((r_state == StWait) && (r_cnt == 4'd1)));

  assign w_legal = sel_legal(w_sel) && (w_addr[31:2] < 30'(DEPTH_WORDS));

  for (genvar i = 0; i < 4; i++) begin : g_bank
    assign w_bank_we[i] = w_enter_resp && w_legal && (w_we == WRITE_ENABLE) && w_sel[i];

    dmem_byte_bank #(
      .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
      .clk    (clk),
      .we_i   (w_bank_we[i]),
      .addr_i (w_addr[AW+1:2]),
      .wdata_i(w_data[8*i +: 8]),
      .rdata_o(w_rdata[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      data_o  <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (r_state)
        StIdle: begin
          if (ce_i == CHIP_ENABLE) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_sel   <= sel_i;
            r_data  <= data_i;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (ce_i != CHIP_ENABLE) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= StResp;
          end
        end
        StResp: begin
          ack_o   <= !r_err;
          err_o   <= r_err;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_enter_resp) begin
        r_err <= !w_legal;
        if (w_legal && (w_we != WRITE_ENABLE)) data_o <= w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce1 = 1'b0;
  logic        ce0 = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dout1, dout0;
  logic        ack1, err1, ack0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(dout1), .ack_o(ack1), .err_o(err1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(dout0), .ack_o(ack0), .err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one request on the selected instance, scrambling inputs after acceptance.
  task automatic txn(input int dut, input logic t_we, input logic [31:0] t_addr,
                     input logic [3:0] t_sel, input logic [31:0] t_data,
                     input logic exp_err, input string tag);
    logic got_ack, got_err;
    int   lat;
    got_ack = 1'b0;
    got_err = 1'b0;
    lat     = -1;
    we = t_we; addr = t_addr; sel = t_sel; wdata = t_data;
    if (dut == 1) ce1 = 1'b1; else ce0 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) begin
        we = ~t_we; addr = t_addr ^ 32'h20; sel = ~t_sel; wdata = ~t_data;
      end
      got_ack = (dut == 1) ? ack1 : ack0;
      got_err = (dut == 1) ? err1 : err0;
      if (got_ack || got_err) begin
        lat = n;
        break;
      end
    end
    ce1 = 1'b0;
    ce0 = 1'b0;
    check({tag, " ack"}, 32'(got_ack), 32'(!exp_err));
    check({tag, " err"}, 32'(got_err), 32'(exp_err));
    check({tag, " latency"}, 32'(lat), (dut == 1) ? 32'd2 : 32'd1);
  endtask

  initial begin
    int seen;
    int cyc;
    logic [31:0] b2b_data [4];
    b2b_data[0] = 32'h11111111; b2b_data[1] = 32'h22222222;
    b2b_data[2] = 32'h33333333; b2b_data[3] = 32'h44444444;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset dout1", dout1, 32'h0);
    check("reset ack1", 32'(ack1), 32'h0);
    check("reset err1", 32'(err1), 32'h0);
    check("reset dout0", dout0, 32'h0);

    txn(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, "wr word");
    txn(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, "rd word");
    check("rd word data", dout1, 32'hDEADBEEF);

    txn(1, 1'b1, 32'h13, 4'b0001, 32'h55555555, 1'b0, "wr byte");
    txn(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, "rd byte");
    check("rd byte data", dout1, 32'hDEADBE55);
    txn(1, 1'b1, 32'h10, 4'b1100, 32'h12341234, 1'b0, "wr half");
    txn(1, 1'b0, 32'h10, 4'b0010, 32'h0, 1'b0, "rd half");
    check("rd half data", dout1, 32'h1234BE55);

    txn(1, 1'b0, 32'h1000, 4'b1111, 32'h0, 1'b1, "rd oob");
    check("rd oob data", dout1, 32'h1234BE55);
    @(negedge clk);
    check("err one cycle", 32'(err1), 32'h0);
    txn(1, 1'b1, 32'h10, 4'b0101, 32'hFFFFFFFF, 1'b1, "wr badsel");
    txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b1, "rd sel0");
    check("rd sel0 data", dout1, 32'h1234BE55);
    txn(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, "rd after bad");
    check("rd after bad data", dout1, 32'h1234BE55);

    // Abort: drop the request while it is waiting.
    we = 1'b1; addr = 32'h10; sel = 4'b1111; wdata = 32'hAAAAAAAA; ce1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ce1 = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    check("abort resp", 32'(seen), 32'h0);
    txn(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, "rd after abort");
    check("rd after abort data", dout1, 32'h1234BE55);

    // Reset while a write is waiting.
    we = 1'b1; addr = 32'h10; sel = 4'b1111; wdata = 32'hCAFEF00D; ce1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst ack", 32'(ack1), 32'h0);
    check("rst err", 32'(err1), 32'h0);
    check("rst dout", dout1, 32'h0);
    rst = 1'b0;
    ce1 = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (ack1 || err1) seen++;
    end
    check("rst no resp", 32'(seen), 32'h0);
    txn(1, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, "rd after rst");
    check("rd after rst data", dout1, 32'h1234BE55);

    // Back-to-back writes with no wait states and the request held high throughout.
    we = 1'b1; sel = 4'b1111; addr = 32'h0; wdata = b2b_data[0]; ce0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ack0 || err0) break;
      end
      check($sformatf("b2b %0d ack", k), 32'(ack0), 32'h1);
      check($sformatf("b2b %0d spacing", k), 32'(cyc), 32'd2);
      if (k < 3) begin
        addr  = 32'((k + 1) * 4);
        wdata = b2b_data[k+1];
      end
    end
    ce0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      txn(0, 1'b0, 32'(k * 4), 4'b1111, 32'h0, 1'b0, $sformatf("b2b rd %0d", k));
      check($sformatf("b2b rd %0d data", k), dout0, b2b_data[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
